// File: rtl/med_stream_if.sv
// Sample-stream bundle between the line-window builder and med_stream.
// Handshake: a sample on DI moves on a rising CLK edge where DSI=1 and RDY=1; DSO is a
// one-cycle pulse marking the cycle on which DO carries a fresh result (no back-pressure).
interface med_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DI;
  logic             DSI;
  logic             RDY;
  logic [WIDTH-1:0] DO;
  logic             DSO;

  modport master (output DI, DSI, input RDY, DO, DSO);
  modport slave  (input DI, DSI, output RDY, DO, DSO);
endinterface

// File: rtl/med_stream.sv
// Streaming N-sample median (or rank) filter built around one compare-exchange unit.
// Optional MED_RANK_SEL_EN adds a RANK input selecting any descending rank instead of the median.
module med_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 9
) (
  input  logic                 CLK,
  input  logic                 nRST,
`ifdef MED_RANK_SEL_EN
  input  logic [$clog2(N)-1:0] RANK,
`endif
  med_stream_if.slave          s,
  output logic [1:0]           dbg_state
);
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(N);
  localparam int P  = (N - 1) / 2;
`ifdef MED_RANK_SEL_EN
  localparam int ROUNDS = N;
`else
  localparam int ROUNDS = P + 1;
`endif
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(N - 2);
  localparam logic [PW-1:0] RND_LAST = PW'(ROUNDS - 1);
  localparam logic [PW-1:0] NM1      = PW'(N - 1);

  if ((N < 3) || (N % 2 == 0)) begin : g_bad_n
    $error("med_stream: N must be odd and >= 3");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] win [N];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cyc;
  logic [PW-1:0]    rnd;
  logic             tail;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] do_q;
  logic             dso_q;
  logic [PW-1:0]    target;
  logic [WIDTH-1:0] cx, cy, hi, lo;

`ifndef MED_RANK_SEL_EN
  assign target = PW'(P);
`endif

  // Each round of N-1 cycles carries the running max in win[N-1] while the rest rotate.
  // At the start of a later round the previous max is retired by replacing it with zero,
  // which can never rise above any remaining live element.
  always_comb begin
    cx = ((rnd != '0) && (cyc == '0)) ? '0 : win[N-1];
    cy = win[N-2];
    hi = (cy > cx) ? cy : cx;
    lo = (cy > cx) ? cx : cy;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (s.DSI) state_n = LOAD;
      LOAD:    if (s.DSI && (cnt == CNT_LAST)) state_n = SORT;
      SORT:    if (tail) state_n = OUT;
      OUT:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      cyc   <= '0;
      rnd   <= '0;
      tail  <= 1'b0;
      res   <= '0;
      do_q  <= '0;
      dso_q <= 1'b0;
      for (int i = 0; i < N; i++) win[i] <= '0;
`ifdef MED_RANK_SEL_EN
      target <= '0;
`endif
    end else begin
      state <= state_n;
      dso_q <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (s.DSI) begin
            for (int i = 1; i < N; i++) win[i] <= win[i-1];
            win[0] <= s.DI;
            cnt    <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
`ifdef MED_RANK_SEL_EN
            if (state == IDLE) target <= (RANK > NM1) ? NM1 : RANK;
`endif
          end
        end
        SORT: begin
          if (tail) begin
            tail  <= 1'b0;
            do_q  <= res;
            dso_q <= 1'b1;
          end else begin
            win[N-1] <= hi;
            win[0]   <= lo;
            for (int i = 1; i < N - 1; i++) win[i] <= win[i-1];
            if ((rnd == target) && (cyc == CYC_LAST)) res <= hi;
            if (cyc == CYC_LAST) begin
              cyc <= '0;
              if (rnd == RND_LAST) begin
                rnd  <= '0;
                tail <= 1'b1;
              end else begin
                rnd <= rnd + PW'(1);
              end
            end else begin
              cyc <= cyc + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign s.RDY     = (state == IDLE) || (state == LOAD);
  assign s.DO      = do_q;
  assign s.DSO     = dso_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_med_stream.sv
// Directed bench for med_stream (N=9, WIDTH=8): vector table, multi-cycle corner sequences,
// and a short randomised run checked against a sorting model.
module tb_med_stream;
  localparam int WIDTH = 8;
  localparam int N     = 9;
`ifdef MED_RANK_SEL_EN
  localparam int LAT = N * (N - 1) + 1;
`else
  localparam int LAT = N * (N - 1) / 2 + (N - 1) / 2 + 1;
`endif

  typedef struct {
    string            name;
    logic [WIDTH-1:0] v [N];
    logic [WIDTH-1:0] exp;
    int               gap;
    logic [3:0]       rk;
  } vec_t;

  logic       clk  = 1'b0;
  logic       nrst = 1'b0;
  logic [3:0] rank = 4'd4;
  logic [1:0] dbg_state;
  int n_cmp = 0;
  int n_err = 0;
  int dso_seen = 0;
  int dso_exp  = 0;
  logic [WIDTH-1:0] exp_q[$];
  vec_t tbl[$];

  med_stream_if #(.WIDTH(WIDTH)) bus();

  med_stream #(.WIDTH(WIDTH), .N(N)) dut (
    .CLK       (clk),
    .nRST      (nrst),
`ifdef MED_RANK_SEL_EN
    .RANK      (rank),
`endif
    .s         (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.DSO === 1'b1) dso_seen++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] v [N], input int r);
    logic [WIDTH-1:0] srt [N];
    logic [WIDTH-1:0] t;
    int k;
    srt = v;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (srt[j] < srt[j+1]) begin
          t = srt[j]; srt[j] = srt[j+1]; srt[j+1] = t;
        end
    k = (r > N - 1) ? N - 1 : r;
    return srt[k];
  endfunction

  // driver: waits for RDY, then feeds N samples with up to max_gap idle cycles before each
  task automatic send_block(input logic [WIDTH-1:0] v [N], input int max_gap);
    int guard = 0;
    while (!bus.RDY && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rdy_before_block", 32'(bus.RDY), 32'd1);
    for (int i = 0; i < N; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      bus.DSI = 1'b0;
      repeat (g) @(negedge clk);
      bus.DI  = v[i];
      bus.DSI = 1'b1;
      @(negedge clk);
    end
    bus.DSI = 1'b0;
  endtask

  // called at the negedge right after the Nth accept; counts edges until DSO
  task automatic wait_result(input string name, input bit flood);
    int n = 0;
    logic [WIDTH-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    dso_exp++;
    if (flood) begin
      bus.DSI = 1'b1;
      bus.DI  = 8'hAA;
    end
    while (n < LAT + 20) begin
      @(negedge clk);
      n++;
      if (n == 1) check({name, "_rdy_sort"}, 32'(bus.RDY), 32'd0);
      if (bus.DSO === 1'b1) break;
    end
    bus.DSI = 1'b0;
    check({name, "_latency"}, 32'(n), 32'(LAT));
    check({name, "_do"}, 32'(bus.DO), 32'(e));
  endtask

  task automatic add_vec(input string name, input logic [WIDTH-1:0] v [N],
                         input logic [WIDTH-1:0] exp, input int gap, input logic [3:0] rk);
    vec_t x;
    x.name = name; x.v = v; x.exp = exp; x.gap = gap; x.rk = rk;
    tbl.push_back(x);
  endtask

  initial begin
    logic [WIDTH-1:0] basic [N];
    logic [WIDTH-1:0] seq   [N];
    logic [WIDTH-1:0] rv    [N];
    int s0;

    basic = '{8'd30, 8'd90, 8'd10, 8'd70, 8'd50, 8'd20, 8'd80, 8'd40, 8'd60};
    for (int i = 0; i < N; i++) seq[i] = WIDTH'(i + 1);

    add_vec("basic",     basic, 8'd50, 0, 4'd4);
    add_vec("gaps",      basic, 8'd50, 3, 4'd4);
    add_vec("all_ff",    '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'hFF, 1, 4'd4);
    add_vec("five_zero", '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00}, 8'h00, 0, 4'd4);
    add_vec("descend",   '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'd5, 2, 4'd4);
    add_vec("ties_mix",  '{8'd200, 8'd3, 8'd200, 8'd3, 8'd200, 8'd3, 8'd7, 8'd7, 8'd7}, 8'd7, 0, 4'd4);
`ifdef MED_RANK_SEL_EN
    add_vec("rank0",  '{8'd3, 8'd7, 8'd1, 8'd9, 8'd5, 8'd2, 8'd8, 8'd4, 8'd6}, 8'd9, 0, 4'd0);
    add_vec("rank8",  '{8'd3, 8'd7, 8'd1, 8'd9, 8'd5, 8'd2, 8'd8, 8'd4, 8'd6}, 8'd1, 0, 4'd8);
    add_vec("rank15", '{8'd3, 8'd7, 8'd1, 8'd9, 8'd5, 8'd2, 8'd8, 8'd4, 8'd6}, 8'd1, 1, 4'd15);
`endif

    bus.DI  = '0;
    bus.DSI = 1'b0;
    nrst    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_do",    32'(bus.DO),    32'd0);
    check("reset_dso",   32'(bus.DSO),   32'd0);
    check("reset_rdy",   32'(bus.RDY),   32'd1);
    check("reset_state", 32'(dbg_state), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    for (int t = 0; t < tbl.size(); t++) begin
      rank = tbl[t].rk;
      exp_q.push_back(tbl[t].exp);
      send_block(tbl[t].v, tbl[t].gap);
      wait_result(tbl[t].name, 1'b0);
    end

    // DSI held high with 0xAA across the whole sort; the next block must be unaffected
    rank = 4'd4;
    exp_q.push_back(8'd50);
    send_block(basic, 0);
    wait_result("dsi_flood", 1'b1);
    exp_q.push_back(8'd5);
    send_block(seq, 0);
    wait_result("after_flood", 1'b0);

    // reset in the middle of SORT discards the block
    send_block(basic, 0);
    repeat (20) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    check("midreset_do",  32'(bus.DO),  32'd0);
    check("midreset_dso", 32'(bus.DSO), 32'd0);
    check("midreset_rdy", 32'(bus.RDY), 32'd1);
    s0 = dso_seen;
    repeat (LAT + 10) @(negedge clk);
    check("midreset_no_dso", 32'(dso_seen), 32'(s0));
    exp_q.push_back(8'd5);
    send_block(seq, 0);
    wait_result("after_reset", 1'b0);

    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < N; i++) rv[i] = WIDTH'($urandom_range(255, 0));
      if (b < 5) for (int i = 0; i < N; i++) rv[i] = WIDTH'($urandom_range(3, 0) * 85);
`ifdef MED_RANK_SEL_EN
      rank = 4'($urandom_range(15, 0));
`endif
      exp_q.push_back(model(rv, int'(rank)));
      send_block(rv, b % 2);
      wait_result("random", 1'b0);
    end

    repeat (3) @(negedge clk);
    check("dso_pulse_count", 32'(dso_seen), 32'(dso_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/med_stream.md
Name: med_stream

Overview:
- Parametrised successor to the fixed 9-tap, 8-bit median filter.
- Window size N and data width WIDTH are generics.
- Load and sort sequencing is generated internally by an FSM, so no external BYP pattern is needed.
- Accepts N samples through a DSI-qualified input, sorts them with a single compare-exchange unit, and emits the median with a DSO strobe.
- Sits in the pixel pipeline between the line-window builder and the output formatter.

Parameters:
- WIDTH, 8: sample width in bits; unsigned.
- N, 9: window size; must be odd and ≥3, otherwise elaboration fails via $error.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset; synchronous, active-low.
- DI  in  WIDTH  sample in; valid when DSI=1.
- DSI  in  1  input strobe; sample accepted when DSI=1 and RDY=1.
- RDY  out  1  block can accept a sample.
- DO  out  WIDTH  result (median, or selected rank).
- DSO  out  1  one-cycle pulse; DO is valid on this cycle.

Behaviour:
- Reset (nRST=0 at a CLK rising edge):
  - state=IDLE, all counters 0, window registers 0.
  - DO=0, DSO=0, RDY=1.
  - Applies from any state, including mid-LOAD or mid-SORT. Any partial block is discarded with no DSO.
- State IDLE (RDY=1):
  - DSI=1: capture DI into window slot 0, cnt=1, go to LOAD.
- State LOAD (RDY=1):
  - Each cycle with DSI=1 shifts DI into the window and increments cnt.
  - DSI=0 cycles are gaps: window and counters hold, no timeout.
  - When the Nth sample is accepted, go to SORT on the next cycle.
- State SORT (RDY=0):
  - Internal equivalent of BYP/DSI sequencing: P=(N-1)/2 passes of N cycles each. Each pass rotates the window through the compare-exchange unit and extracts the current maximum.
  - Then (N-1)/2 closing cycles.
  - DSI is ignored; DI is not sampled.
- State OUT (RDY=0), 1 cycle:
  - DO <= median, DSO=1.
  - Next state is IDLE, with RDY=1 on the following cycle.
- Latency: from the CLK edge that accepts the Nth sample to the edge where DSO=1 is L = N*(N-1)/2 + (N-1)/2 + 1 cycles. N=9 gives 41; N=5 gives 13.
- Hold behaviour: DO holds its value until the next OUT or reset. DSO is 0 in every cycle except OUT.
- Throughput: next block may start on the cycle after OUT. Minimum period is N+L+1 cycles.
- Comparison rules:
  - Unsigned, full WIDTH, no truncation.
  - Equal values do not exchange. Ties yield the correct median value; which copy is kept is irrelevant.
  - Median = element at index (N-1)/2 of the descending-sorted window.
- Counter widths: sample and cycle counters use $clog2(N+1) bits; pass counter uses $clog2(N) bits. No wrap is possible within one block.

Optional Feature:
- Macro: MED_RANK_SEL_EN.
- Defined:
  - Adds port RANK, input, $clog2(N) bits.
  - RANK is sampled on the cycle the first sample of a block is accepted and held for that block.
  - Output is the element of descending rank RANK: 0=max, N-1=min.
  - RANK≥N saturates to N-1.
  - SORT runs N-1 full passes, giving fixed latency L = N*(N-1)+1 independent of RANK. N=9 gives 73.
- Undefined:
  - No RANK port; median only; latency as above.

Test Plan:
- Median, basic: N=9, WIDTH=8; DI=30,90,10,70,50,20,80,40,60 on consecutive DSI cycles -> DO=50, DSO=1 exactly 41 cycles after the 9th accept; RDY=0 during SORT.
- Gaps and ties: same 9 values with 0–3 random DSI=0 gaps between samples -> DO=50, same latency measured from the 9th accept. All-0xFF window -> DO=0xFF. Window of 5×0x00 and 4×0xFF -> DO=0x00.
- Reset mid-operation: assert nRST=0 for 1 cycle at SORT cycle 20 -> DSO never fires for that block, DO=0, RDY=1 next cycle; next block 1..9 -> DO=5.
- DSI ignored during SORT: DSI=1 with DI=0xAA throughout SORT -> result unaffected; the sample is not counted toward the next block.
- Random regression: 1000 back-to-back random blocks for each of N=9/WIDTH=8, N=5/WIDTH=12, N=3/WIDTH=1, checked against a software sort -> zero mismatches; exactly one DSO per block.
- Rank select (MED_RANK_SEL_EN): N=9, values 1..9 shuffled:
  - RANK=0 -> 9.
  - RANK=8 -> 1.
  - RANK=15 -> 1 (saturated).
  - All three with DSO at 73 cycles.
